shift_add_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier that generalises the fixed 8-bit A/B shift-register pair into a complete WIDTH-bit multiplier.
- Holds a sign/carry bit X, accumulator A and multiplier B, and latches the multiplicand M from S at start.
- Runs one conditional add/subtract and one right shift per multiplier bit.
- Selects signed (two's complement) or unsigned mode per operation.
- Sits between the switch/button debounce logic and the hex-display drivers.

---
 rtl/mult_pkg.sv | 16 +
 rtl/shift_reg_n.sv | 31 +++
 rtl/shift_add_multiplier.sv | 136 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and sizing helper for the shift-add multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  // Bit count needed to index WIDTH multiplier steps (0..WIDTH-1).
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - WIDTH-bit register with parallel load, right shift and clear
module shift_reg_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic             msb_fill,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (shift_en) begin
      q <= {msb_fill, q[WIDTH-1:1]};
    end
  end

  assign value = q;
  assign lsb   = q[0];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential signed/unsigned shift-add multiplier, one add and one shift per bit
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ClearA_LoadB,
  input  logic               Run,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   S,
  output logic               Busy,
  output logic               Done,
  output logic               X,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CW = count_width(WIDTH);

  mult_state_t      state;
  logic [WIDTH-1:0] m_reg;
  logic             x_reg;
  logic             mode;
  logic [CW-1:0]    count;

  logic             a_lsb;
  logic             b_lsb;
  logic             idle_like;
  logic             load_b;
  logic             accept;
  logic             last;
  logic             add_en;
  logic             shift_en;
  logic             clear_a;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign load_b    = idle_like && ClearA_LoadB;
  assign accept    = (state == IDLE) && !ClearA_LoadB && Run;
  assign last      = (count == CW'(WIDTH - 1));
  assign add_en    = (state == ADD) && b_lsb;
  assign shift_en  = (state == SHIFT);
  assign clear_a   = load_b || accept;

  // The sign bit of the multiplier carries negative weight, so the final step subtracts.
  always_comb begin
    a_ext = mode ? {A[WIDTH-1], A} : {1'b0, A};
    m_ext = mode ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};
    sum   = (mode && last) ? (a_ext - m_ext) : (a_ext + m_ext);
  end

  shift_reg_n #(.WIDTH(WIDTH)) a_reg (
    .clk        (Clk),
    .reset      (Reset),
    .clear      (clear_a),
    .load       (add_en),
    .shift_en   (shift_en),
    .msb_fill   (x_reg),
    .load_value (sum[WIDTH-1:0]),
    .value      (A),
    .lsb        (a_lsb)
  );

  shift_reg_n #(.WIDTH(WIDTH)) b_reg (
    .clk        (Clk),
    .reset      (Reset),
    .clear      (1'b0),
    .load       (load_b),
    .shift_en   (shift_en),
    .msb_fill   (a_lsb),
    .load_value (S),
    .value      (B),
    .lsb        (b_lsb)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      x_reg <= 1'b0;
      m_reg <= '0;
      mode  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            x_reg <= 1'b0;
          end else if (Run) begin
            m_reg <= S;
            x_reg <= 1'b0;
            mode  <= Signed_Mode;
            count <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          if (b_lsb) begin
            x_reg <= sum[WIDTH];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          if (!mode) begin
            x_reg <= 1'b0;
          end
          if (last) begin
            state <= DONE;
          end else begin
            count <= count + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          // Holding Run parks here so a held button yields a single product.
          if (ClearA_LoadB) begin
            x_reg <= 1'b0;
          end else if (!Run) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy    = (state == ADD) || (state == SHIFT);
  assign Done    = (state == DONE);
  assign X       = x_reg;
  assign Product = {A, B};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed vector bench for shift_add_multiplier at WIDTH 8 and 16
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        clr8 = 1'b0, run8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  s8 = '0;
  logic        busy8, done8, x8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        clr16 = 1'b0, run16 = 1'b0, sm16 = 1'b0;
  logic [15:0] s16 = '0;
  logic        busy16, done16, x16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(reset), .ClearA_LoadB(clr8), .Run(run8), .Signed_Mode(sm8), .S(s8),
    .Busy(busy8), .Done(done8), .X(x8), .A(a8), .B(b8), .Product(p8)
  );

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(reset), .ClearA_LoadB(clr16), .Run(run16), .Signed_Mode(sm16), .S(s16),
    .Busy(busy16), .Done(done16), .X(x16), .A(a16), .B(b16), .Product(p16)
  );

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  m;
    logic        sm;
    logic [15:0] p;
    logic        x;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!done8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Load B, then start with S as multiplicand; returns edges from accept to first Done.
  task automatic op8(input logic [7:0] b, input logic [7:0] m, input logic sm, output int cyc);
    @(negedge clk); clr8 = 1'b1; run8 = 1'b0; s8 = b;
    @(negedge clk); clr8 = 1'b0; run8 = 1'b1; s8 = m; sm8 = sm;
    @(posedge clk); #1;
    s8 = 8'h5A; sm8 = ~sm;
    wait_done8(cyc);
  endtask

  initial begin
    int cyc;
    logic busy_seen, done_low;

    vecs[0]  = '{8'h07, 8'hFD, 1'b1, 16'hFFEB, 1'b1};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0};
    vecs[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b0};
    vecs[4]  = '{8'h00, 8'h5A, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{8'h0C, 8'h0A, 1'b0, 16'h0078, 1'b0};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 16'h4000, 1'b0};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b0};
    vecs[8]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1};
    vecs[9]  = '{8'h05, 8'hFB, 1'b1, 16'hFFE7, 1'b1};
    vecs[10] = '{8'hAA, 8'h55, 1'b0, 16'h3872, 1'b0};
    vecs[11] = '{8'hAA, 8'h55, 1'b1, 16'hE372, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy8), 32'h0);
    check("reset_done", 32'(done8), 32'h0);
    check("reset_product", 32'(p8), 32'h0);
    check("reset_x", 32'(x8), 32'h0);
    check("reset_product16", p16, 32'h0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      op8(vecs[i].b, vecs[i].m, vecs[i].sm, cyc);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd16);
      check($sformatf("vec%0d_product", i), 32'(p8), 32'(vecs[i].p));
      check($sformatf("vec%0d_x", i), 32'(x8), 32'(vecs[i].x));
      @(negedge clk); run8 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_drop", i), 32'(done8), 32'h0);
    end

    // Run held long after completion: one computation only.
    op8(8'h80, 8'h80, 1'b1, cyc);
    check("hold_product", 32'(p8), 32'h4000);
    busy_seen = 1'b0; done_low = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy8) busy_seen = 1'b1;
      if (!done8) done_low = 1'b1;
    end
    check("hold_busy_never", 32'(busy_seen), 32'h0);
    check("hold_done_stays", 32'(done_low), 32'h0);
    check("hold_product_stable", 32'(p8), 32'h4000);

    // ClearA_LoadB honoured in DONE without leaving DONE.
    @(negedge clk); clr8 = 1'b1; s8 = 8'h11;
    @(posedge clk); #1;
    check("done_clr_done", 32'(done8), 32'h1);
    check("done_clr_b", 32'(b8), 32'h11);
    check("done_clr_a", 32'(a8), 32'h0);
    @(negedge clk); clr8 = 1'b0; run8 = 1'b0;
    @(posedge clk); #1;
    check("done_exit", 32'(done8), 32'h0);

    // Reuse B=0x11 without reloading.
    @(negedge clk); run8 = 1'b1; s8 = 8'h03; sm8 = 1'b0;
    @(posedge clk); #1;
    wait_done8(cyc);
    check("reuse_b_product", 32'(p8), 32'h0033);
    @(negedge clk); run8 = 1'b0;

    // ClearA_LoadB and Run together in IDLE: load only.
    @(negedge clk); clr8 = 1'b1; run8 = 1'b1; s8 = 8'h33; sm8 = 1'b0;
    @(posedge clk); #1;
    check("clr_run_busy", 32'(busy8), 32'h0);
    check("clr_run_b", 32'(b8), 32'h33);
    @(negedge clk); clr8 = 1'b0; s8 = 8'h02;
    @(posedge clk); #1;
    check("run_after_clr_busy", 32'(busy8), 32'h1);
    wait_done8(cyc);
    check("run_after_clr_product", 32'(p8), 32'h0066);
    @(negedge clk); run8 = 1'b0;

    // ClearA_LoadB while busy is ignored.
    @(negedge clk); clr8 = 1'b1; s8 = 8'h0C;
    @(negedge clk); clr8 = 1'b0; run8 = 1'b1; s8 = 8'h0A; sm8 = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk); clr8 = 1'b1; s8 = 8'hFF; sm8 = 1'b1;
    @(negedge clk); clr8 = 1'b0;
    @(posedge clk); #1;
    wait_done8(cyc);
    check("busy_clr_product", 32'(p8), 32'h0078);
    @(negedge clk); run8 = 1'b0;

    // WIDTH=16 signed corner.
    @(negedge clk); clr16 = 1'b1; s16 = 16'h8000;
    @(negedge clk); clr16 = 1'b0; run16 = 1'b1; s16 = 16'h7FFF; sm16 = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done16 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_latency", 32'(cyc), 32'd32);
    check("w16_product", p16, 32'hC0008000);
    check("w16_x", 32'(x16), 32'h1);
    @(negedge clk); run16 = 1'b0;

    // Reset in cycle 5 of an operation.
    @(negedge clk); clr8 = 1'b1; s8 = 8'h07;
    @(negedge clk); clr8 = 1'b0; run8 = 1'b1; s8 = 8'hFD; sm8 = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy", 32'(busy8), 32'h0);
    check("midreset_done", 32'(done8), 32'h0);
    check("midreset_a", 32'(a8), 32'h0);
    check("midreset_b", 32'(b8), 32'h0);
    check("midreset_x", 32'(x8), 32'h0);
    @(negedge clk); reset = 1'b0; run8 = 1'b0;
    @(posedge clk); #1;
    check("after_reset_idle", 32'(busy8), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
